// File: rtl/ac_store_pkg.sv
// Shared types and defaults for the accumulator store (write-back) path.
package ac_store_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        DONE,
        ERR
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/store_timer.sv
// Loadable, clearable down-counter with terminal-count flag; times both the
// SETUP hold and the WRITE acknowledge timeout.
module store_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Saturates at zero instead of wrapping, so a held dec cannot re-arm the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ac_store_unit.sv
// Accumulator write-back unit: captures a store command, then drives a
// setup-hold / we-ack write into data memory and reports done or timeout.
module ac_store_unit
    import ac_store_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] ac_data,
    output logic              st_busy,
    output logic              st_done,
    output logic              st_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack
);

    localparam int               CNT_W       = $clog2(max_int(SETUP_CYCLES, TIMEOUT) + 1);
    localparam bit               HAS_TIMEOUT = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WRITE_LOAD  = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state;
    logic             timer_clear;
    logic             timer_load;
    logic             timer_dec;
    logic [CNT_W-1:0] timer_value;
    logic             timer_tc;

    // The timer is loaded with (cycles - 1) on state entry, so terminal count
    // marks the last cycle of SETUP or the TIMEOUT-th unacknowledged WRITE cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        timer_clear = 1'b0;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        timer_value = '0;
        case (state)
            IDLE: begin
                if (st_req) begin
                    timer_load  = 1'b1;
                    timer_value = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (timer_tc) begin
                    timer_load  = 1'b1;
                    timer_value = WRITE_LOAD;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            WRITE: begin
                if (mem_ack || (HAS_TIMEOUT && timer_tc)) begin
                    timer_clear = 1'b1;
                end else begin
                    timer_dec = HAS_TIMEOUT;
                end
            end
            default: timer_clear = 1'b1;
        endcase
    end

    store_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (timer_clear),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .tc         (timer_tc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            st_busy   <= 1'b0;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (st_req) begin
                        state     <= SETUP;
                        st_busy   <= 1'b1;
                        mem_addr  <= st_addr;
                        mem_wdata <= ac_data;
                    end
                end
                SETUP: begin
                    if (timer_tc) begin
                        state  <= WRITE;
                        mem_we <= 1'b1;
                    end
                end
                WRITE: begin
                    // An ack on the expiry edge still counts as success.
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_we  <= 1'b0;
                        st_done <= 1'b1;
                    end else if (HAS_TIMEOUT && timer_tc) begin
                        state  <= ERR;
                        mem_we <= 1'b0;
                        st_err <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    state   <= IDLE;
                    st_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    st_busy <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ac_store_unit.sv
// Scoreboard bench for ac_store_unit: the driver pushes the expected outcome of
// each store, a negedge monitor pops and compares when done/err is reported.
module tb_ac_store_unit;

    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 16;
    localparam int SETUP_CYCLES = 1;
    localparam int TIMEOUT      = 15;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              st_req = 1'b0;
    logic [ADDR_W-1:0] st_addr = '0;
    logic [DATA_W-1:0] ac_data = '0;
    logic              st_busy;
    logic              st_done;
    logic              st_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_ack = 1'b0;

    ac_store_unit #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .SETUP_CYCLES (SETUP_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .st_req    (st_req),
        .st_addr   (st_addr),
        .ac_data   (ac_data),
        .st_busy   (st_busy),
        .st_done   (st_done),
        .st_err    (st_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                is_err;
        int                we_cycles;
        int                latency;
        int                req_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   vectors     = 0;
    int   miscompares = 0;
    int   we_cnt      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_we) begin
                we_cnt++;
                check("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("wr_addr", mem_addr, exp_q[0].addr);
                    check("wr_data", mem_wdata, exp_q[0].data);
                    check("busy_in_write", st_busy, 1'b1);
                end
            end
            if (st_done || st_err) begin
                check("pulse_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("st_done", st_done, !cur.is_err);
                    check("st_err", st_err, cur.is_err);
                    check("we_cycles", we_cnt, cur.we_cycles);
                    check("latency", cyc - cur.req_cyc, cur.latency);
                    check("we_low_in_report", mem_we, 1'b0);
                end
                we_cnt = 0;
            end
        end
    end

    // Reference: a write acked within TIMEOUT cycles completes after ack_at
    // strobe cycles; otherwise it errors after exactly TIMEOUT strobe cycles.
    function automatic exp_t model(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                   input int ack_at);
        exp_t e;
        e.addr = addr;
        e.data = data;
        if (ack_at != 0 && (TIMEOUT == 0 || ack_at <= TIMEOUT)) begin
            e.is_err    = 1'b0;
            e.we_cycles = ack_at;
        end else begin
            e.is_err    = 1'b1;
            e.we_cycles = TIMEOUT;
        end
        e.latency = SETUP_CYCLES + e.we_cycles + 1;
        e.req_cyc = 0;
        return e;
    endfunction

    // ack_at: strobe cycle in which mem_ack is asserted (0 = never).
    task automatic run_store(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                             input int ack_at, input bit drop_setup, input bit drop_done);
        exp_t e;
        int   wcount = 0;
        bit   fin    = 1'b0;
        e = model(addr, data, ack_at);
        tick();
        st_req  = 1'b1;
        st_addr = addr;
        ac_data = data;
        mem_ack = 1'b0;
        e.req_cyc = cyc;
        exp_q.push_back(e);
        tick();
        st_req  = drop_setup;
        st_addr = drop_setup ? 16'h0041 : ADDR_W'($urandom);
        ac_data = drop_setup ? 16'hBEEF : DATA_W'($urandom);
        mem_ack = 1'($urandom_range(0, 1));
        for (int i = 0; i < 200 && !fin; i++) begin
            tick();
            st_req = 1'b0;
            if (st_done || st_err) begin
                fin     = 1'b1;
                mem_ack = 1'b0;
                if (drop_done) begin
                    st_req  = 1'b1;
                    st_addr = 16'h0041;
                    ac_data = 16'hBEEF;
                end
            end else if (mem_we) begin
                wcount++;
                mem_ack = (wcount == ack_at);
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
        end
        check("store_finished", fin, 1'b1);
        tick();
        st_req  = 1'b0;
        mem_ack = 1'b0;
        check("idle_busy", st_busy, 1'b0);
        check("hold_addr", mem_addr, addr);
        check("hold_data", mem_wdata, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        check("rst_busy", st_busy, 1'b0);
        check("rst_done", st_done, 1'b0);
        check("rst_err", st_err, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, '0);
        check("rst_data", mem_wdata, '0);
        reset = 1'b0;
        tick();

        run_store(16'h0040, 16'h1234, 1, 1'b0, 1'b0);           // basic
        run_store(16'h0040, 16'h1234, 6, 1'b0, 1'b0);           // 5 wait states
        run_store(16'h0200, 16'h5A5A, 0, 1'b0, 1'b0);           // timeout
        run_store(16'h0300, 16'hA5A5, TIMEOUT, 1'b0, 1'b0);     // ack on expiry edge
        run_store(16'h0040, 16'h1234, 1, 1'b1, 1'b1);           // busy drops

        // Reset while the write strobe is active
        tick();
        st_req  = 1'b1;
        st_addr = 16'h0100;
        ac_data = 16'hCAFE;
        exp_q.push_back(model(16'h0100, 16'hCAFE, 0));
        tick();
        st_req = 1'b0;
        n = 0;
        for (int i = 0; i < 50 && n < 3; i++) begin
            tick();
            if (mem_we) n++;
        end
        check("reached_write", n, 3);
        exp_q.delete();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        we_cnt = 0;
        check("abort_we", mem_we, 1'b0);
        check("abort_busy", st_busy, 1'b0);
        check("abort_done", st_done, 1'b0);
        check("abort_err", st_err, 1'b0);
        check("abort_addr", mem_addr, '0);
        check("abort_data", mem_wdata, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_pulse", st_done | st_err | mem_we, 1'b0);
        end
        run_store(16'h0055, 16'h0F0F, 2, 1'b0, 1'b0);

        // Randomized stores; ack_at beyond TIMEOUT exercises the error path
        for (int t = 0; t < 20; t++) begin
            run_store(ADDR_W'($urandom), DATA_W'($urandom), int'($urandom_range(0, TIMEOUT + 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
